// File: rtl/systolic_pe.sv
// ============================================================================
// Module   : systolic_pe
// Purpose  : Weight-stationary signed multiply-accumulate PE for a systolic array.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_pe #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      w_en,
  input  logic                      w_compute,
  input  logic [DATA_WIDTH-1:0]     active_left,
  output logic [DATA_WIDTH-1:0]     active_right,
  input  logic [2*DATA_WIDTH-1:0]   in_sum,
  output logic [2*DATA_WIDTH-1:0]   out_sum,
  input  logic [DATA_WIDTH-1:0]     in_weight_above
);

  localparam int c_SUM_W = 2 * DATA_WIDTH;

  logic [DATA_WIDTH-1:0] r_weight_q;
  logic [DATA_WIDTH-1:0] r_active_right;
  logic [c_SUM_W-1:0]    r_out_sum;

  logic [c_SUM_W-1:0]    w_act_ext;
  logic [c_SUM_W-1:0]    w_wgt_ext;
  logic [c_SUM_W-1:0]    w_product;
  logic [c_SUM_W-1:0]    w_mac;

  // Low 2N bits of an unsigned product of sign-extended operands equal the signed product.
  assign w_act_ext = {{DATA_WIDTH{active_left[DATA_WIDTH-1]}}, active_left};
  assign w_wgt_ext = {{DATA_WIDTH{r_weight_q[DATA_WIDTH-1]}}, r_weight_q};
  assign w_product = w_act_ext * w_wgt_ext;
  assign w_mac     = in_sum + w_product;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_weight_q     <= '0;
      r_active_right <= '0;
      r_out_sum      <= '0;
    end else begin
      if (w_en) begin
        r_weight_q <= in_weight_above;
      end
      if (w_compute) begin
        r_out_sum      <= w_mac;
        r_active_right <= active_left;
      end
    end
  end

  assign active_right = r_active_right;
  assign out_sum      = r_out_sum;

endmodule

`default_nettype wire

// File: tb/tb_systolic_pe.sv
// ============================================================================
// Module   : tb_systolic_pe
// Purpose  : Scoreboard bench for systolic_pe against an integer-arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_systolic_pe;

  localparam int DW = 23;
  localparam int SW = 2 * DW;

  typedef struct {
    logic [SW-1:0] s;
    logic [DW-1:0] a;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          w_en;
  logic          w_compute;
  logic [DW-1:0] active_left;
  logic [DW-1:0] active_right;
  logic [SW-1:0] in_sum;
  logic [SW-1:0] out_sum;
  logic [DW-1:0] in_weight_above;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  // Reference state: weight kept as a plain signed integer.
  longint        m_w;
  logic [SW-1:0] m_sum;
  logic [DW-1:0] m_act;

  systolic_pe #(.DATA_WIDTH(DW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .w_en            (w_en),
    .w_compute       (w_compute),
    .active_left     (active_left),
    .active_right    (active_right),
    .in_sum          (in_sum),
    .out_sum         (out_sum),
    .in_weight_above (in_weight_above)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check("out_sum", 64'(out_sum), 64'(e.s));
      check("active_right", 64'(active_right), 64'(e.a));
    end
  end

  task automatic step(input bit en, input bit comp, input int wa, input int al, input longint is);
    longint e;
    exp_t   x;
    w_en            = en;
    w_compute       = comp;
    in_weight_above = wa[DW-1:0];
    active_left     = al[DW-1:0];
    in_sum          = is[SW-1:0];
    if (comp) begin
      e     = is + longint'(al) * m_w;
      m_sum = e[SW-1:0];
      m_act = al[DW-1:0];
    end
    if (en) m_w = longint'(wa);
    x.s = m_sum;
    x.a = m_act;
    @(posedge clk);
    sb_q.push_back(x);
    #2;
  endtask

  function automatic int rnd(input int lim);
    return int'($urandom_range(2 * lim)) - lim;
  endfunction

  task automatic rand_inputs_en_high();
    w_en            = 1'b1;
    w_compute       = 1'b1;
    in_weight_above = DW'($urandom);
    active_left     = DW'($urandom);
    in_sum          = {$urandom, $urandom} & {SW{1'b1}};
  endtask

  initial begin
    m_w = 0; m_sum = '0; m_act = '0;
    rst_n = 1'b0;
    rand_inputs_en_high();
    #1;
    check("reset_sum_immediate", 64'(out_sum), 64'd0);
    check("reset_act_immediate", 64'(active_right), 64'd0);
    repeat (3) begin
      @(negedge clk);
      rand_inputs_en_high();
      check("reset_sum_held", 64'(out_sum), 64'd0);
      check("reset_act_held", 64'(active_right), 64'd0);
    end
    #1 rst_n = 1'b1;

    // Load then compute: 3*5+7.
    step(1'b1, 1'b0, 5, 3, 7);
    step(1'b0, 1'b1, 0, 3, 7);
    // Signed: -3*4 + -2.
    step(1'b1, 1'b0, -3, 9, 11);
    step(1'b0, 1'b1, 0, 4, -2);
    // Overlap: compute sees old weight 2, next compute sees 9.
    step(1'b1, 1'b0, 2, 0, 0);
    step(1'b1, 1'b1, 9, 1, 0);
    step(1'b0, 1'b1, 0, 1, 0);

    for (int i = 0; i < 50; i++) step(1'b1, 1'b0, rnd(15), rnd(15), longint'(rnd(31)));
    for (int i = 0; i < 50; i++) step(1'($urandom), 1'b1, rnd(15), rnd(15), longint'(rnd(31)));
    for (int i = 0; i < 8; i++)  step(1'($urandom), 1'b0, rnd(15), rnd(15), longint'(rnd(31)));

    // Asynchronous reset mid-operation, away from any edge.
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    rand_inputs_en_high();
    #1;
    check("midrun_reset_sum", 64'(out_sum), 64'd0);
    check("midrun_reset_act", 64'(active_right), 64'd0);
    repeat (2) begin
      @(negedge clk);
      #1;
      check("midrun_reset_sum_held", 64'(out_sum), 64'd0);
      check("midrun_reset_act_held", 64'(active_right), 64'd0);
    end
    m_w = 0; m_sum = '0; m_act = '0;
    rst_n = 1'b1;
    // Weight must have been cleared: result equals in_sum.
    step(1'b0, 1'b1, 0, 5, 100);
    step(1'b1, 1'b1, -7, -6, -1);
    step(1'b0, 1'b1, 0, 6, 3);

    @(negedge clk);
    #1;
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
